// File: rtl/layer_compositor_if.sv
// ----------------------------------------------------------------------------
// layer_compositor_if
//
// Purpose: bundles every source layer, raw timing input and composited
// output of layer_compositor so the source side and the compositor connect
// through one port.
//
// Flow: the bus is a free-running stream of one pixel per clock with no
// valid/ready pair. The source side presents a new set of layer pixels and
// raw timing every cycle. The compositor always accepts them; there is no
// backpressure.
//
// Signals (source side drives -> compositor side):
//   game_state[2:0]     0 WELCOME, 1 START, 2 PLAY, 3 PAUSE, 4 FINISH
//   player_en[NP-1:0]   per-player presence mask
//   player_pixels       player i at [i*PIX_W +: PIX_W]
//   object_pixel        static-sprite layer
//   in_grid             source pixel lies inside the counter grid
//   floor_pixel         tables/floor layer
//   info_pixel          order-display layer (0 = none)
//   welcome_pixel       welcome art (0 = none)
//   hsync, vsync, blank raw timing (syncs active low)
//   time_left[7:0]      only with LAYER_COMPOSITOR_LOW_TIME_FLASH_EN
// Signals (compositor side drives -> source side):
//   hsync_out, vsync_out, blank_out   delayed timing
//   pixel_out           composited pixel
//   frame_tick          one-cycle pulse per raw vsync falling edge
//   level[3:0]          current brightness level
//   fade_state[1:0]     debug view of the fade state machine
//
// Modports: master = source/driver side, slave = compositor.
// ----------------------------------------------------------------------------
interface layer_compositor_if #(
    parameter int NUM_PLAYERS = 4,
    parameter int PIX_W       = 12
);
    logic [2:0]                   game_state;
    logic [NUM_PLAYERS-1:0]       player_en;
    logic [NUM_PLAYERS*PIX_W-1:0] player_pixels;
    logic [PIX_W-1:0]             object_pixel;
    logic                         in_grid;
    logic [PIX_W-1:0]             floor_pixel;
    logic [PIX_W-1:0]             info_pixel;
    logic [PIX_W-1:0]             welcome_pixel;
    logic                         hsync;
    logic                         vsync;
    logic                         blank;
`ifdef LAYER_COMPOSITOR_LOW_TIME_FLASH_EN
    logic [7:0]                   time_left;
`endif
    logic                         hsync_out;
    logic                         vsync_out;
    logic                         blank_out;
    logic [PIX_W-1:0]             pixel_out;
    logic                         frame_tick;
    logic [3:0]                   level;
    logic [1:0]                   fade_state;

    modport master (
        output game_state, player_en, player_pixels, object_pixel, in_grid,
               floor_pixel, info_pixel, welcome_pixel, hsync, vsync, blank,
`ifdef LAYER_COMPOSITOR_LOW_TIME_FLASH_EN
               time_left,
`endif
        input  hsync_out, vsync_out, blank_out, pixel_out, frame_tick, level,
               fade_state
    );

    modport slave (
        input  game_state, player_en, player_pixels, object_pixel, in_grid,
               floor_pixel, info_pixel, welcome_pixel, hsync, vsync, blank,
`ifdef LAYER_COMPOSITOR_LOW_TIME_FLASH_EN
               time_left,
`endif
        output hsync_out, vsync_out, blank_out, pixel_out, frame_tick, level,
               fade_state
    );
endinterface

// File: rtl/layer_compositor.sv
// ----------------------------------------------------------------------------
// layer_compositor
//
// Purpose: merges the kitchen-display sprite layers into one VGA pixel,
// delays raw sync/blank to line up with the sprite-source latency, and fades
// brightness down while the game is paused (one step per frame).
//
// Ports:
//   clock   pixel clock
//   reset   asynchronous, active-high
//   bus     layer_compositor_if.slave (layers and raw timing in, delayed
//           timing, composited pixel, frame_tick, level and fade state out)
//
// Optional feature: define LAYER_COMPOSITOR_LOW_TIME_FLASH_EN to add the
// time_left input and a 4-on/4-off red flash on out-of-grid background
// pixels while playing with little time left.
// ----------------------------------------------------------------------------
module layer_compositor #(
    parameter int               NUM_PLAYERS  = 4,
    parameter int               PIX_W        = 12,
    parameter int               SRC_LATENCY  = 2,
    parameter logic [PIX_W-1:0] TRANSPARENT  = 12'hFFF,
    parameter int               DIM_LEVEL    = 6,
    parameter int               FLASH_THRESH = 10
) (
    input  logic               clock,
    input  logic               reset,
    layer_compositor_if.slave  bus
);
    localparam logic [2:0] GS_WELCOME = 3'd0;
    localparam logic [2:0] GS_PLAY    = 3'd2;
    localparam logic [2:0] GS_PAUSE   = 3'd3;

    // A dim level of 15 or more means "never dim": clamp into 4 bits.
    localparam int         DIM_CLAMP = (DIM_LEVEL > 15) ? 15 : DIM_LEVEL;
    localparam logic [3:0] DIM_L     = DIM_CLAMP[3:0];

    typedef enum logic [1:0] {BRIGHT, DIMMING, DIM, BRIGHTENING} fade_t;

    function automatic logic [3:0] sat_add(input logic [3:0] a, input logic [3:0] b);
        logic [4:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[4] ? 4'hF : s[3:0];
    endfunction

    // (c * (level + 1)) >> 4; the product never exceeds 240, so 8 bits hold it.
    function automatic logic [3:0] scale(input logic [3:0] c, input logic [3:0] lvl);
        logic [7:0] p;
        p = {4'd0, c} * ({4'd0, lvl} + 8'd1);
        return 4'(p >> 4);
    endfunction

    // ---------------- timing delay line ----------------
    // Stage k holds {hsync, vsync, blank} from k+1 cycles ago.
    logic [2:0] tdly_q [0:SRC_LATENCY];
    logic       blank_next;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k <= SRC_LATENCY; k++) tdly_q[k] <= 3'b111;
        end else begin
            tdly_q[0] <= {bus.hsync, bus.vsync, bus.blank};
            for (int k = 1; k <= SRC_LATENCY; k++) tdly_q[k] <= tdly_q[k-1];
        end
    end

    // The pixel register must be gated by the blank value that blank_out
    // will show in the same cycle, i.e. one stage before the end of the line.
    generate
        if (SRC_LATENCY == 0) begin : g_no_lat
            assign blank_next = bus.blank;
        end else begin : g_lat
            assign blank_next = tdly_q[SRC_LATENCY-1][0];
        end
    endgenerate

    assign bus.hsync_out = tdly_q[SRC_LATENCY][2];
    assign bus.vsync_out = tdly_q[SRC_LATENCY][1];
    assign bus.blank_out = tdly_q[SRC_LATENCY][0];

    // ---------------- frame tick ----------------
    logic vsync_prev_q;
    logic frame_tick_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vsync_prev_q <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            vsync_prev_q <= bus.vsync;
            frame_tick_q <= vsync_prev_q & ~bus.vsync;
        end
    end

    assign bus.frame_tick = frame_tick_q;

    // ---------------- fade FSM ----------------
    fade_t      state_q, state_d;
    logic [3:0] level_q, level_d;
    logic       pause;
    logic       go_dn, go_up;

    assign pause = (bus.game_state == GS_PAUSE);

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        go_dn   = 1'b0;
        go_up   = 1'b0;
        // game_state is only looked at on a tick, so level never moves mid-frame.
        if (frame_tick_q) begin
            case (state_q)
                BRIGHT:      go_dn = pause;
                DIM:         go_up = !pause;
                DIMMING,
                BRIGHTENING: begin
                    go_dn = pause;
                    go_up = !pause;
                end
                default:     go_up = 1'b1;
            endcase
        end
        if (go_dn) begin
            if (level_q > DIM_L) begin
                level_d = level_q - 4'd1;
                state_d = (level_q - 4'd1 == DIM_L) ? DIM : DIMMING;
            end else begin
                state_d = DIM;
            end
        end
        if (go_up) begin
            if (level_q != 4'hF) begin
                level_d = level_q + 4'd1;
                state_d = (level_q + 4'd1 == 4'hF) ? BRIGHT : BRIGHTENING;
            end else begin
                state_d = BRIGHT;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= BRIGHT;
            level_q <= 4'hF;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
        end
    end

    assign bus.level      = level_q;
    assign bus.fade_state = state_q;

    // ---------------- layer priority ----------------
    // Built lowest priority first so each higher layer simply overrides.
    logic [PIX_W-1:0] sel_pix;
    logic             from_sum;

    always_comb begin
        sel_pix  = {sat_add(bus.floor_pixel[11:8], bus.info_pixel[11:8]),
                    sat_add(bus.floor_pixel[7:4],  bus.info_pixel[7:4]),
                    sat_add(bus.floor_pixel[3:0],  bus.info_pixel[3:0])};
        from_sum = 1'b1;
        if (bus.in_grid && bus.object_pixel != TRANSPARENT) begin
            sel_pix  = bus.object_pixel;
            from_sum = 1'b0;
        end
        // Descending scan: the lowest visible index is written last and wins.
        for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
            if (bus.player_en[i] && bus.player_pixels[i*PIX_W +: PIX_W] != TRANSPARENT) begin
                sel_pix  = bus.player_pixels[i*PIX_W +: PIX_W];
                from_sum = 1'b0;
            end
        end
        if (bus.game_state == GS_WELCOME && bus.welcome_pixel != '0) begin
            sel_pix  = bus.welcome_pixel;
            from_sum = 1'b0;
        end
    end

    // ---------------- optional low-time tint ----------------
    logic [PIX_W-1:0] tint_pix;

`ifdef LAYER_COMPOSITOR_LOW_TIME_FLASH_EN
    logic [2:0] frame_cnt_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)             frame_cnt_q <= 3'd0;
        else if (frame_tick_q) frame_cnt_q <= frame_cnt_q + 3'd1;
    end

    always_comb begin
        tint_pix = sel_pix;
        if (bus.game_state == GS_PLAY && 32'(bus.time_left) < FLASH_THRESH &&
            frame_cnt_q[2] && from_sum && !bus.in_grid) begin
            tint_pix[11:8] = 4'hF;
        end
    end
`else
    logic unused_from_sum;
    assign unused_from_sum = from_sum;
    assign tint_pix        = sel_pix;
`endif

    // ---------------- scale, blank and register ----------------
    logic [PIX_W-1:0] pixel_q, pixel_d;

    always_comb begin
        pixel_d = {scale(tint_pix[11:8], level_q),
                   scale(tint_pix[7:4],  level_q),
                   scale(tint_pix[3:0],  level_q)};
        if (blank_next) pixel_d = '0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) pixel_q <= '0;
        else       pixel_q <= pixel_d;
    end

    assign bus.pixel_out = pixel_q;
endmodule

// File: tb/tb_layer_compositor.sv
// ----------------------------------------------------------------------------
// tb_layer_compositor: self-checking bench for layer_compositor.
// Every cycle the outputs are compared with a history-based reference model;
// a vector table and hand-written fade/reset/flash sequences add direct
// checks against hand-computed constants.
// ----------------------------------------------------------------------------
module tb_layer_compositor;
    localparam int NP  = 4;
    localparam int PW  = 12;
    localparam int LAT = 2;
    localparam int DIM = 6;
    localparam int FT  = 10;
    localparam int FRAME = 16;
`ifdef LAYER_COMPOSITOR_LOW_TIME_FLASH_EN
    localparam bit FLASH_EN = 1'b1;
`else
    localparam bit FLASH_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    layer_compositor_if #(.NUM_PLAYERS(NP), .PIX_W(PW)) bus();

    layer_compositor #(
        .NUM_PLAYERS(NP), .PIX_W(PW), .SRC_LATENCY(LAT),
        .TRANSPARENT(12'hFFF), .DIM_LEVEL(DIM), .FLASH_THRESH(FT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [2:0]  gs;
        logic [3:0]  en;
        logic [47:0] pp;
        logic [11:0] obj;
        logic        ing;
        logic [11:0] flr;
        logic [11:0] inf;
        logic [11:0] wel;
        logic        hs;
        logic        vs;
        logic        bl;
        logic [7:0]  tl;
    } in_t;

    typedef struct {
        in_t         in;
        logic [11:0] exp;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: per-cycle history since the last reset release.
    in_t hist[$];
    int  lvl_m[$];
    int  cnt_m[$];
    bit  tick_m[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic in_t idle();
        in_t r;
        r.gs = 3'd2; r.en = 4'b0; r.pp = {4{12'hFFF}}; r.obj = 12'hFFF;
        r.ing = 1'b0; r.flr = 12'h000; r.inf = 12'h000; r.wel = 12'h000;
        r.hs = 1'b1; r.vs = 1'b1; r.bl = 1'b1; r.tl = 8'd200;
        return r;
    endfunction

    // Brightness walks one step per frame toward its target.
    function automatic int fade(input int lv, input logic [2:0] gs);
        if (gs == 3'd3) return (lv > DIM) ? lv - 1 : lv;
        return (lv < 15) ? lv + 1 : 15;
    endfunction

    function automatic logic [11:0] compose(input in_t r, input int lvl, input int cnt, input bit blank);
        int ch[3];
        bit found;
        bit from_sum;
        logic [11:0] base;
        logic [11:0] res;
        found = 0; from_sum = 0; base = 12'h000;
        if (blank) return 12'h000;
        if (r.gs == 3'd0 && r.wel != 12'h000) begin
            base = r.wel; found = 1;
        end
        for (int i = 0; i < NP; i++) begin
            if (!found && r.en[i] && r.pp[i*12 +: 12] != 12'hFFF) begin
                base = r.pp[i*12 +: 12]; found = 1;
            end
        end
        if (!found && r.ing && r.obj != 12'hFFF) begin
            base = r.obj; found = 1;
        end
        for (int k = 0; k < 3; k++) begin
            ch[k] = int'(r.flr[k*4 +: 4]) + int'(r.inf[k*4 +: 4]);
            if (ch[k] > 15) ch[k] = 15;
        end
        if (!found) begin
            from_sum = 1;
            base = {ch[2][3:0], ch[1][3:0], ch[0][3:0]};
        end
        if (FLASH_EN && from_sum && !r.ing && r.gs == 3'd2 && r.tl < FT && cnt >= 4)
            base[11:8] = 4'hF;
        for (int k = 0; k < 3; k++) begin
            int v;
            v = (int'(base[k*4 +: 4]) * (lvl + 1)) / 16;
            res[k*4 +: 4] = v[3:0];
        end
        return res;
    endfunction

    // ---------------- driver task ----------------
    // Called just after a rising edge: check the current cycle against the
    // model, apply the next inputs, advance one clock.
    task automatic step(input in_t r);
        int c;
        bit tk;
        int lv, cn;
        bit bl_old;
        logic [11:0] ep;
        c = hist.size();
        if (c == 0) begin
            tk = 0; lv = 15; cn = 0;
        end else begin
            tk = (c >= 2 ? hist[c-2].vs : 1'b1) & ~hist[c-1].vs;
            lv = lvl_m[c-1];
            cn = cnt_m[c-1];
            if (tick_m[c-1]) begin
                lv = fade(lv, hist[c-1].gs);
                cn = (cn + 1) % 8;
            end
        end
        tick_m.push_back(tk);
        lvl_m.push_back(lv);
        cnt_m.push_back(cn);
        check("hsync_out", bus.hsync_out, (c - LAT - 1 >= 0) ? hist[c-LAT-1].hs : 1'b1);
        check("vsync_out", bus.vsync_out, (c - LAT - 1 >= 0) ? hist[c-LAT-1].vs : 1'b1);
        check("blank_out", bus.blank_out, (c - LAT - 1 >= 0) ? hist[c-LAT-1].bl : 1'b1);
        check("frame_tick", bus.frame_tick, tk);
        check("level", bus.level, lv);
        if (c >= 1) begin
            bl_old = (c - 1 - LAT >= 0) ? hist[c-1-LAT].bl : 1'b1;
            ep = compose(hist[c-1], lvl_m[c-1], cnt_m[c-1], bl_old);
        end else begin
            ep = 12'h000;
        end
        check("pixel_out", bus.pixel_out, ep);

        bus.game_state    = r.gs;
        bus.player_en     = r.en;
        bus.player_pixels = r.pp;
        bus.object_pixel  = r.obj;
        bus.in_grid       = r.ing;
        bus.floor_pixel   = r.flr;
        bus.info_pixel    = r.inf;
        bus.welcome_pixel = r.wel;
        bus.hsync         = r.hs;
        bus.vsync         = r.vs;
        bus.blank         = r.bl;
`ifdef LAYER_COMPOSITOR_LOW_TIME_FLASH_EN
        bus.time_left     = r.tl;
`endif
        hist.push_back(r);
        @(posedge clock);
        #1;
    endtask

    // Asynchronous reset in the middle of a cycle: outputs must change at once.
    task automatic do_reset();
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("rst_hsync_out", bus.hsync_out, 1'b1);
        check("rst_vsync_out", bus.vsync_out, 1'b1);
        check("rst_blank_out", bus.blank_out, 1'b1);
        check("rst_pixel_out", bus.pixel_out, 12'h000);
        check("rst_frame_tick", bus.frame_tick, 1'b0);
        check("rst_level", bus.level, 4'hF);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        hist.delete();
        lvl_m.delete();
        cnt_m.delete();
        tick_m.delete();
    endtask

    // One frame of constant content; vsync is low on the first two cycles.
    // The level is checked at the end of the frame, after the tick has landed.
    task automatic run_frame(input in_t base, input int exp_lvl, input string name);
        in_t r;
        for (int f = 0; f < FRAME; f++) begin
            r = base;
            r.vs = (f < 2) ? 1'b0 : 1'b1;
            step(r);
        end
        check(name, bus.level, exp_lvl);
    endtask

    vec_t tbl[10];

    initial begin : main
        in_t r;
        in_t b;
        int gs_now;

        // ---------------- table ----------------
        for (int i = 0; i < 10; i++) begin
            tbl[i].in = idle();
            tbl[i].in.bl = 1'b0;
        end
        tbl[0].in.en = 4'b0110; tbl[0].in.pp[12 +: 12] = 12'h0A0; tbl[0].in.pp[24 +: 12] = 12'h00F;
        tbl[0].in.obj = 12'h123; tbl[0].in.ing = 1'b1; tbl[0].exp = 12'h0A0;
        tbl[1].in = tbl[0].in; tbl[1].in.en = 4'b0100; tbl[1].exp = 12'h00F;
        tbl[2].in = tbl[0].in; tbl[2].in.en = 4'b0000; tbl[2].exp = 12'h123;
        tbl[3].in.flr = 12'h9C4; tbl[3].in.inf = 12'h884; tbl[3].exp = 12'hFF8;
        tbl[4].in.gs = 3'd0; tbl[4].in.wel = 12'h555; tbl[4].in.en = 4'b0001;
        tbl[4].in.pp[0 +: 12] = 12'h0A5; tbl[4].exp = 12'h555;
        tbl[5].in = tbl[4].in; tbl[5].in.wel = 12'h000; tbl[5].exp = 12'h0A5;
        tbl[6].in.obj = 12'h123; tbl[6].in.flr = 12'h111; tbl[6].in.inf = 12'h222; tbl[6].exp = 12'h333;
        tbl[7].in.en = 4'b1111; tbl[7].in.ing = 1'b1; tbl[7].in.flr = 12'h0F0;
        tbl[7].in.inf = 12'h00F; tbl[7].exp = 12'h0FF;
        tbl[8].in.en = 4'b1001; tbl[8].in.pp[36 +: 12] = 12'hABC; tbl[8].exp = 12'hABC;
        tbl[9].in.wel = 12'h555; tbl[9].in.flr = 12'h100; tbl[9].exp = 12'h100;

        // ---------------- reset release + timing delay ----------------
        r = idle();
        bus.game_state = r.gs; bus.player_en = r.en; bus.player_pixels = r.pp;
        bus.object_pixel = r.obj; bus.in_grid = r.ing; bus.floor_pixel = r.flr;
        bus.info_pixel = r.inf; bus.welcome_pixel = r.wel; bus.hsync = r.hs;
        bus.vsync = r.vs; bus.blank = r.bl;
`ifdef LAYER_COMPOSITOR_LOW_TIME_FLASH_EN
        bus.time_left = r.tl;
`endif
        do_reset();
        for (int c = 0; c < 17; c++) begin
            if (c >= 12 && c <= 14) begin
                check("hsync_pulse", bus.hsync_out, (c == 13) ? 1'b0 : 1'b1);
                check("blank_pix", bus.pixel_out, 12'h000);
            end
            r = idle();
            r.flr = 12'h357;
            r.hs = (c == 10) ? 1'b0 : 1'b1;
            step(r);
        end

        // ---------------- table-driven priority vectors ----------------
        for (int w = 0; w < 4; w++) begin
            r = idle(); r.bl = 1'b0; step(r);
        end
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].in);
            check("table_pix", bus.pixel_out, tbl[i].exp);
        end

        // ---------------- pause fade down and hold ----------------
        b = idle(); b.bl = 1'b0; b.gs = 3'd3; b.flr = 12'hFFF;
        for (int k = 1; k <= 12; k++) run_frame(b, (15 - k > DIM) ? 15 - k : DIM, "fade_down");
        check("dim_pix", bus.pixel_out, 12'h666);

        // ---------------- reset mid-fade, then reverse at level 9 ----------------
        do_reset();
        for (int k = 1; k <= 6; k++) run_frame(b, 15 - k, "fade_to_9");
        b.gs = 3'd2;
        for (int k = 1; k <= 8; k++) run_frame(b, (9 + k < 15) ? 9 + k : 15, "fade_up");
        check("bright_pix", bus.pixel_out, 12'hFFF);

        // ---------------- randomized stimulus vs model ----------------
        gs_now = 2;
        for (int c = 0; c < 720; c++) begin
            if (c % 24 == 0) gs_now = ($urandom_range(0, 1) == 1) ? 3 : int'($urandom_range(0, 4));
            r.gs  = 3'(gs_now);
            r.en  = 4'($urandom);
            for (int i = 0; i < NP; i++)
                r.pp[i*12 +: 12] = ($urandom_range(0, 1) == 1) ? 12'hFFF : 12'($urandom);
            r.obj = ($urandom_range(0, 1) == 1) ? 12'hFFF : 12'($urandom);
            r.ing = 1'($urandom);
            r.flr = 12'($urandom);
            r.inf = ($urandom_range(0, 2) == 0) ? 12'h000 : 12'($urandom);
            r.wel = ($urandom_range(0, 1) == 1) ? 12'h000 : 12'($urandom);
            r.hs  = ($urandom_range(0, 3) != 0);
            r.vs  = ((c % 24) >= 2);
            r.bl  = ($urandom_range(0, 3) == 0);
            r.tl  = 8'($urandom_range(0, 20));
            step(r);
        end

`ifdef LAYER_COMPOSITOR_LOW_TIME_FLASH_EN
        // ---------------- low-time flash ----------------
        do_reset();
        b = idle(); b.bl = 1'b0; b.gs = 3'd2; b.tl = 8'd5; b.flr = 12'h222;
        for (int k = 1; k <= 16; k++) begin
            run_frame(b, 15, "flash_level");
            check("flash_pix", bus.pixel_out, ((k % 8) >= 4) ? 12'hF22 : 12'h222);
        end
        b.tl = 8'd10;
        for (int k = 1; k <= 8; k++) begin
            run_frame(b, 15, "noflash_level");
            check("noflash_pix", bus.pixel_out, 12'h222);
        end
`endif

        // ---------------- report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
